// File: rtl/pwm_pkg.sv
// Shared defaults, FSM state type and duty slew rule for the dual PWM drive.
package pwm_pkg;

    localparam int unsigned DUTY_W_DEF    = 6;
    localparam int unsigned PRESC_W_DEF   = 8;
    localparam int unsigned PRESC_DIV_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // Move the applied duty one LSB toward the request, or hold when equal.
    function automatic logic [DUTY_W_DEF-1:0] next_duty(
        input logic [DUTY_W_DEF-1:0] act,
        input logic [DUTY_W_DEF-1:0] req
    );
        if (req > act) begin
            return act + 1'b1;
        end else if (req < act) begin
            return act - 1'b1;
        end else begin
            return act;
        end
    endfunction

endpackage

// File: rtl/pwm_dual_drive_if.sv
// Control/status bundle of the dual PWM drive: duty requests in, pulses and readback out.
interface pwm_dual_drive_if #(
    parameter int unsigned DUTY_W = pwm_pkg::DUTY_W_DEF
);

    logic              Enable;
    logic [DUTY_W-1:0] DC_X;
    logic [DUTY_W-1:0] DC_Y;
    logic              PWM_X;
    logic              PWM_Y;
    logic              Period_Strt;
    logic              Busy;
    logic [DUTY_W-1:0] Duty_Act_X;
    logic [DUTY_W-1:0] Duty_Act_Y;

    modport master (
        output Enable, DC_X, DC_Y,
        input  PWM_X, PWM_Y, Period_Strt, Busy, Duty_Act_X, Duty_Act_Y
    );

    modport slave (
        input  Enable, DC_X, DC_Y,
        output PWM_X, PWM_Y, Period_Strt, Busy, Duty_Act_X, Duty_Act_Y
    );

endinterface

// File: rtl/pwm_prescaler.sv
// Divides sysclk down to the PWM tick; counter held at zero while clr is high.
module pwm_prescaler #(
    parameter int unsigned PRESC_W   = 8,
    parameter int unsigned PRESC_DIV = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESC_DIV - 1);

    logic [PRESC_W-1:0] presc_cnt;

    assign tick = !clr && (presc_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (clr || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_dual_drive.sv
// Two-channel fixed-period PWM; duty words sampled only at period starts.
// Optional PWM_SLEW_EN: each load moves the applied duty by at most one LSB.
module pwm_dual_drive
    import pwm_pkg::*;
#(
    parameter int unsigned DUTY_W    = DUTY_W_DEF,
    parameter int unsigned PRESC_W   = PRESC_W_DEF,
    parameter int unsigned PRESC_DIV = PRESC_DIV_DEF
) (
    input  logic            sysclk,
    input  logic            Reset_n,
    pwm_dual_drive_if.slave bus
);

    state_t            state_q;
    state_t            state_d;
    logic              tick;
    logic              wrap;
    logic              load;
    logic              to_idle;
    logic [DUTY_W-1:0] cnt_q;
    logic [DUTY_W-1:0] duty_x_q;
    logic [DUTY_W-1:0] duty_y_q;
    logic [DUTY_W-1:0] load_x;
    logic [DUTY_W-1:0] load_y;
    logic              pwm_x_q;
    logic              pwm_y_q;
    logic              pstrt_q;

    pwm_prescaler #(
        .PRESC_W   (PRESC_W),
        .PRESC_DIV (PRESC_DIV)
    ) u_presc (
        .clk   (sysclk),
        .rst_n (Reset_n),
        .clr   (state_q == IDLE),
        .tick  (tick)
    );

    assign wrap = tick && (cnt_q == '1);

`ifdef PWM_SLEW_EN
    assign load_x = next_duty(duty_x_q, bus.DC_X);
    assign load_y = next_duty(duty_y_q, bus.DC_Y);
`else
    assign load_x = bus.DC_X;
    assign load_y = bus.DC_Y;
`endif

    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A wrap in RUN always loads, even when Enable falls on that cycle.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        to_idle = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Enable) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                load = wrap;
                if (!bus.Enable) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bus.Enable) begin
                    state_d = RUN;
                    load    = wrap;
                end else if (wrap) begin
                    state_d = IDLE;
                    to_idle = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q    <= '0;
            duty_x_q <= '0;
            duty_y_q <= '0;
            pwm_x_q  <= 1'b0;
            pwm_y_q  <= 1'b0;
            pstrt_q  <= 1'b0;
        end else begin
            pstrt_q <= load;
            if (load) begin
                duty_x_q <= load_x;
                duty_y_q <= load_y;
            end
            if (state_q == IDLE) begin
                cnt_q <= '0;
            end else if (tick) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if ((state_q == IDLE) || to_idle) begin
                pwm_x_q <= 1'b0;
                pwm_y_q <= 1'b0;
            end else begin
                pwm_x_q <= (cnt_q < duty_x_q);
                pwm_y_q <= (cnt_q < duty_y_q);
            end
        end
    end

    assign bus.PWM_X       = pwm_x_q;
    assign bus.PWM_Y       = pwm_y_q;
    assign bus.Period_Strt = pstrt_q;
    assign bus.Busy        = (state_q != IDLE);
    assign bus.Duty_Act_X  = duty_x_q;
    assign bus.Duty_Act_Y  = duty_y_q;

endmodule
